// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier:
// FSM states, Booth select codes and the iteration-count helper.
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Booth select is {Q[0], Q-1}
   localparam logic [1:0] SEL_SHIFT0 = 2'b00;
   localparam logic [1:0] SEL_ADD    = 2'b01;
   localparam logic [1:0] SEL_SUB    = 2'b10;
   localparam logic [1:0] SEL_SHIFT1 = 2'b11;

   // One extra iteration covers the extension bit of the WIDTH+1-bit multiplier.
   function automatic int iters(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/subtract of the multiplicand
// into A, then an arithmetic right shift of {A, Q, Q-1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH+1:0] a,
   input  logic [WIDTH:0]   q,
   input  logic             q_m1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH+1:0] a_next,
   output logic [WIDTH:0]   q_next,
   output logic             q_m1_next
);

   logic [WIDTH+1:0] sum_s;

   // Add or subtract the sign-extended multiplicand according to the Booth pair.
   always_comb begin
      sum_s = a;
      case ({q[0], q_m1})
         SEL_ADD:    sum_s = a + {m[WIDTH], m};
         SEL_SUB:    sum_s = a - {m[WIDTH], m};
         SEL_SHIFT0: sum_s = a;
         SEL_SHIFT1: sum_s = a;
         default:    sum_s = a;
      endcase
   end

   assign a_next    = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
   assign q_next    = {sum_s[0], q[WIDTH:1]};
   assign q_m1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-2 Booth sequential multiplier, signed or unsigned operands,
// WIDTH+1 iterations per product with a one-cycle done pulse.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   ip1,
   input  logic [WIDTH-1:0]   ip2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] op
);

   localparam int ITERS = iters(WIDTH);
   localparam int CNT_W = $clog2(ITERS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   state_t             state_r, state_s;
   logic [WIDTH+1:0]   a_r, a_s, a_step_s;
   logic [WIDTH:0]     q_r, q_s, q_step_s;
   logic               qm1_r, qm1_s, qm1_step_s;
   logic [WIDTH:0]     m_r, m_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [2*WIDTH-1:0] op_r, op_s;
   logic               done_r, done_s;
   logic               busy_r, busy_s;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a         (a_r),
      .q         (q_r),
      .q_m1      (qm1_r),
      .m         (m_r),
      .a_next    (a_step_s),
      .q_next    (q_step_s),
      .q_m1_next (qm1_step_s)
   );

   // Next-state, datapath load/iterate and output decode.
   always_comb begin
      state_s = state_r;
      a_s     = a_r;
      q_s     = q_r;
      qm1_s   = qm1_r;
      m_s     = m_r;
      cnt_s   = cnt_r;
      op_s    = op_r;
      done_s  = 1'b0;
      busy_s  = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_s     = {(WIDTH+2){1'b0}};
               q_s     = {signed_mode & ip2[WIDTH-1], ip2};
               m_s     = {signed_mode & ip1[WIDTH-1], ip1};
               qm1_s   = 1'b0;
               cnt_s   = {CNT_W{1'b0}};
               busy_s  = 1'b1;
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_s   = a_step_s;
            q_s   = q_step_s;
            qm1_s = qm1_step_s;
            cnt_s = cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
               // Final {A,Q} low bits: Q supplies WIDTH+1, A supplies the rest.
               op_s    = {a_step_s[WIDTH-2:0], q_step_s};
               done_s  = 1'b1;
               state_s = ST_DONE;
            end else begin
               busy_s  = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         a_r     <= {(WIDTH+2){1'b0}};
         q_r     <= {(WIDTH+1){1'b0}};
         qm1_r   <= 1'b0;
         m_r     <= {(WIDTH+1){1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         op_r    <= {(2*WIDTH){1'b0}};
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         a_r     <= a_s;
         q_r     <= q_s;
         qm1_r   <= qm1_s;
         m_r     <= m_s;
         cnt_r   <= cnt_s;
         op_r    <= op_s;
         done_r  <= done_s;
         busy_r  <= busy_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign op   = op_r;

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only when busy=0.
REQ-005 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-006 SHALL have port ip1, input, WIDTH bits: multiplicand; captured on the accepted start.
REQ-007 SHALL have port ip2, input, WIDTH bits: multiplier; captured on the accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid product.
REQ-010 SHALL have port op, output, 2*WIDTH bits: registered product, held until the next completion.

Function
REQ-011 SHALL implement a radix-2 Booth sequential multiplier with FSM states IDLE, RUN and DONE.
REQ-012 SHALL extend operands internally to WIDTH+1 bits: sign-extend when signed_mode=1, zero-extend when signed_mode=0.
REQ-013 SHALL use a WIDTH+2-bit accumulator A, a WIDTH+1-bit register Q and a 1-bit register Q-1, so that negating -2^(WIDTH-1) never overflows.
REQ-014 SHALL, in IDLE or DONE with start=1 at edge E, load A=0, Q=extended ip2, Q-1=0 and iteration count=0, and enter RUN.
REQ-015 SHALL perform one iteration per edge in RUN, selected by {Q[0],Q-1}: 00/11 shift only; 01 add M then shift; 10 subtract M then shift; the shift is an arithmetic right shift of {A,Q,Q-1}.
REQ-016 SHALL execute exactly WIDTH+1 iterations, at edges E+1..E+WIDTH+1, independent of signed_mode.
REQ-017 SHALL, at edge E+WIDTH+1, write op = low 2*WIDTH bits of the final {A,Q}, set done=1 and enter DONE.
REQ-018 SHALL make DONE last one cycle: done returns to 0 at the next edge, and the FSM goes to IDLE, or to RUN if start=1.
REQ-019 SHALL hold busy=1 in RUN only; busy=0 in IDLE and DONE.
REQ-020 SHALL ignore start, ip1, ip2 and signed_mode while in RUN; captured operands are unaffected by input changes.
REQ-021 SHALL keep op unchanged except at completion.
REQ-022 SHALL accept start in the DONE cycle back-to-back; the new operation's edge E is that DONE edge.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-RUN, asynchronously force the FSM to IDLE, op=0, done=0, busy=0 and clear A, Q, Q-1 and the iteration count.
REQ-024 SHALL discard an aborted operation, produce no done pulse for it, and accept start on the first edge after rst_n deasserts.

Structure
REQ-025 SHALL take the FSM state enum, the ITERS=WIDTH+1 derivation helper and the Booth select codes from shared package booth_pkg.
REQ-026 SHALL place the combinational add/subtract and arithmetic-shift step in one sub-module, booth_step, parametrised by WIDTH.
REQ-027 SHALL hold all sequential state (FSM, counter, A/Q/Q-1, op, done) in booth_seq_mult.

Verification
REQ-028 SHALL cover WIDTH=4 signed: ip1=4'hC, ip2=4'h4 -> op=8'hF0, done exactly 5 edges after the start edge, busy high for those 5 cycles.
REQ-029 SHALL cover WIDTH=4 signed: 4'hB x 4'h8 -> 8'h28; 4'h2 x 4'hE -> 8'hFC; 4'h8 x 4'h8 -> 8'h40 (most-negative case).
REQ-030 SHALL cover WIDTH=4 unsigned: 4'hC x 4'h4 -> 8'h30; 4'hF x 4'hF -> 8'hE1.
REQ-031 SHALL cover WIDTH=8 signed: 8'h80 x 8'h80 -> 16'h4000; 8'hFF x 8'h01 -> 16'hFFFF; unsigned 8'hFF x 8'hFF -> 16'hFE01.
REQ-032 SHALL cover start re-asserted with new operands mid-RUN: both are ignored and the original product is delivered; a back-to-back start in the DONE cycle yields the second product WIDTH+1 edges later.
REQ-033 SHALL cover rst_n pulsed low at iteration 2: busy=0, done=0 and op=0 immediately; no done pulse follows; a fresh start then completes correctly.
